vga_bounce_pixel: RTL and testbench
===================================

VGA_BOUNCE_PIXEL -- requirements
Module: vga_bounce_pixel

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 The block SHALL have these parameters:
- BOX_SIZE, default 32: box edge length in pixels.
- STEP, default 2: pixels moved per frame on each axis.
- BLINK_BIT, default 5: frame-counter bit that gates box visibility.
REQ-003 The block SHALL have these ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- hcnt  in  10  horizontal counter from the timing generator (0..799).
- vcnt  in  10  vertical counter from the timing generator (0..524).
- hsync_in  in  1  hsync from the timing generator, active low.
- vsync_in  in  1  vsync from the timing generator, active low.
- hsync_out  out  1  hsync_in delayed one cycle.
- vsync_out  out  1  vsync_in delayed one cycle.
- px_r, px_g, px_b  out  1 each  registered pixel colour.

Function
REQ-004 All outputs SHALL be registered with exactly 1 cycle latency from hcnt/vcnt/sync inputs, so sync and colour stay aligned.
REQ-005 Active area SHALL be hcnt<640 && vcnt<480; outside it, RGB SHALL be 000.
REQ-006 Box hit SHALL be box_x<=hcnt<box_x+BOX_SIZE && box_y<=vcnt<box_y+BOX_SIZE, compared at 11 bits (no wrap).
REQ-007 Colour priority inside the active area SHALL be:
- box hit with frame_cnt[BLINK_BIT]==0 → colour_idx;
- else border (hcnt==0, hcnt==639, vcnt==0 or vcnt==479) → 001 (blue);
- else 000.
REQ-008 The frame tick SHALL be hcnt==799 && vcnt==524; all motion state SHALL update only on the frame tick.
REQ-009 frame_cnt SHALL be 6-bit, increment on each frame tick and wrap 63→0.
REQ-010 Each axis SHALL be a two-state machine, INC/DEC, with limits X_MAX=640-BOX_SIZE (608) and Y_MAX=480-BOX_SIZE (448):
- INC, pos<MAX → pos+=STEP;
- INC, pos==MAX → go DEC, pos=MAX-STEP;
- DEC, pos>0 → pos-=STEP;
- DEC, pos==0 → go INC, pos=STEP.
REQ-011 STEP SHALL divide both X_MAX and Y_MAX, so positions stay on the STEP grid and hit the limits exactly.
REQ-012 A direction flip on either axis SHALL be a bounce event; colour_idx (3-bit) SHALL then increment by 1 and skip 000 (111→001).
REQ-013 A simultaneous bounce on both axes (corner) SHALL increment colour_idx once only.
REQ-014 Inputs outside the legal ranges (hcnt>799, vcnt>524) SHALL produce RGB 000 and no frame tick.

Reset
REQ-015 On rst, on the clock edge, the block SHALL set:
- box_x=0, box_y=0, both axes INC;
- frame_cnt=0, colour_idx=111;
- px_r/g/b=0;
- hsync_out=1, vsync_out=1.
REQ-016 rst asserted mid-frame SHALL take priority over a coincident frame tick; motion resumes from the reset values at the next frame tick after release.

Structure
REQ-017 Shared package vga_pkg SHALL hold H_ACTIVE=640, V_ACTIVE=480, H_TOTAL=800, V_TOTAL=525 and the axis-state encoding, shared with the timing generator.
REQ-018 One sub-module, bounce_axis, parameterised by MAX and STEP, SHALL implement REQ-010; it is instantiated twice and outputs pos and a bounce pulse.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset: rst for 2 cycles → RGB=000, syncs=1, box at (0,0), colour_idx=111.
- First frame: hcnt=5, vcnt=5 after reset → RGB=111 one cycle later; hcnt=700 → 000; hcnt=639, vcnt=100 → 001.
- Motion: one frame tick → box at (2,2); 304 ticks → box_x=608; next tick → box_x=606, colour_idx=001.
- Blink: frame_cnt=32..63 → box pixels show border or 000; frame_cnt=0 again → box visible.
- Corner: preload box_x=606, box_y=446, both INC; two ticks → both flip on the same tick, colour_idx increments by 1 only.
- Alignment and mid-frame reset: sync toggles emerge 1 cycle late; rst at hcnt=799, vcnt=524 → box stays (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants and types.
// Holds the 640x480@60 timing geometry used by the timing generator and the
// pixel blocks, the per-axis direction encoding and the debug view of the
// bouncing-box state.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;

  // Direction of one motion axis.
  typedef enum logic {
    AXIS_INC = 1'b0,
    AXIS_DEC = 1'b1
  } axis_state_e;

  // Motion state of the box. It is exported so the axis FSMs can be observed
  // without poking into the hierarchy.
  typedef struct packed {
    logic [9:0]  box_x;
    logic [9:0]  box_y;
    axis_state_e dir_x;
    axis_state_e dir_y;
    logic [5:0]  frame_cnt;
    logic [2:0]  colour_idx;
  } bounce_dbg_t;

  // Advance the colour index by one. 000 (black) is skipped so the box never
  // disappears into the background.
  function automatic logic [2:0] next_colour(input logic [2:0] c);
    return (c == 3'b111) ? 3'b001 : c + 3'd1;
  endfunction

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing box: a position that ping-pongs between 0 and MAX
// in STEP increments, advancing only on frame ticks.
// MAX must be a multiple of STEP so the position lands exactly on both ends.
//
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset (pos=0, direction INC)
//   tick_i   frame tick, the only time the position moves
//   pos_o    current position (registered)
//   dir_o    current direction (registered FSM state)
//   bounce_o high in the tick cycle whose edge flips the direction
module bounce_axis
  import vga_pkg::*;
#(
  parameter int MAX  = 608,
  parameter int STEP = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  output logic [9:0]  pos_o,
  output axis_state_e dir_o,
  output logic        bounce_o
);

  localparam logic [9:0] MAX_L  = 10'(MAX);
  localparam logic [9:0] STEP_L = 10'(STEP);

  axis_state_e state_q, state_d;
  logic [9:0]  pos_q, pos_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= AXIS_INC;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
    end
  end

  // At a limit the flip and the first step away happen on the same tick, so
  // the position never rests at the limit for two frames.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    bounce_o = 1'b0;
    if (tick_i) begin
      case (state_q)
        AXIS_INC: begin
          if (pos_q == MAX_L) begin
            state_d  = AXIS_DEC;
            pos_d    = MAX_L - STEP_L;
            bounce_o = 1'b1;
          end else begin
            pos_d = pos_q + STEP_L;
          end
        end
        AXIS_DEC: begin
          if (pos_q == '0) begin
            state_d  = AXIS_INC;
            pos_d    = STEP_L;
            bounce_o = 1'b1;
          end else begin
            pos_d = pos_q - STEP_L;
          end
        end
        default: begin
          state_d = AXIS_INC;
          pos_d   = '0;
        end
      endcase
    end
  end

  assign pos_o = pos_q;
  assign dir_o = state_q;

endmodule

// File: rtl/vga_bounce_pixel.sv
// Bouncing-box pixel generator. Draws a BOX_SIZE square that moves STEP
// pixels per frame on each axis, bounces off the active-area edges, changes
// colour on every bounce and blinks off for half of every 64-frame period.
// A one-pixel blue border frames the active area.
//
// Ports:
//   clk, rst             pixel clock, synchronous active-high reset
//   hcnt, vcnt           raster position from the timing generator
//   hsync_in, vsync_in   active-low syncs from the timing generator
//   hsync_out, vsync_out syncs delayed one cycle to match the colour
//   px_r, px_g, px_b     registered pixel colour
//   dbg_o                box position, directions, frame and colour counters
module vga_bounce_pixel
  import vga_pkg::*;
#(
  parameter int BOX_SIZE  = 32,
  parameter int STEP      = 2,
  parameter int BLINK_BIT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hcnt,
  input  logic [9:0]  vcnt,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        px_r,
  output logic        px_g,
  output logic        px_b,
  output bounce_dbg_t dbg_o
);

  localparam int X_MAX = H_ACTIVE - BOX_SIZE;
  localparam int Y_MAX = V_ACTIVE - BOX_SIZE;

  localparam logic [9:0]  H_ACT_L  = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT_L  = 10'(V_ACTIVE);
  localparam logic [9:0]  H_LAST_L = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST_L = 10'(V_TOTAL - 1);
  localparam logic [10:0] BOX_L    = 11'(BOX_SIZE);

  logic        frame_tick;
  logic [9:0]  box_x, box_y;
  axis_state_e dir_x, dir_y;
  logic        bounce_x, bounce_y;

  logic [5:0]  frame_cnt_q, frame_cnt_d;
  logic [2:0]  colour_q, colour_d;
  logic [2:0]  rgb_q, rgb_d;
  logic        hsync_q, vsync_q;

  logic        active, border, hit;
  logic [10:0] h11, v11, bx11, by11;

  // Exact match on the last raster position: out-of-range counters never
  // produce a tick.
  assign frame_tick = (hcnt == H_LAST_L) && (vcnt == V_LAST_L);

  bounce_axis #(.MAX(X_MAX), .STEP(STEP)) u_axis_x (
    .clk_i   (clk),
    .rst_i   (rst),
    .tick_i  (frame_tick),
    .pos_o   (box_x),
    .dir_o   (dir_x),
    .bounce_o(bounce_x)
  );

  bounce_axis #(.MAX(Y_MAX), .STEP(STEP)) u_axis_y (
    .clk_i   (clk),
    .rst_i   (rst),
    .tick_i  (frame_tick),
    .pos_o   (box_y),
    .dir_o   (dir_y),
    .bounce_o(bounce_y)
  );

  // Hit test at 11 bits so box_x+BOX_SIZE cannot wrap past 1023.
  assign h11  = {1'b0, hcnt};
  assign v11  = {1'b0, vcnt};
  assign bx11 = {1'b0, box_x};
  assign by11 = {1'b0, box_y};

  assign active = (hcnt < H_ACT_L) && (vcnt < V_ACT_L);
  assign hit    = (h11 >= bx11) && (h11 < bx11 + BOX_L) &&
                  (v11 >= by11) && (v11 < by11 + BOX_L);
  assign border = (hcnt == '0) || (hcnt == H_ACT_L - 10'd1) ||
                  (vcnt == '0) || (vcnt == V_ACT_L - 10'd1);

  always_comb begin
    rgb_d = 3'b000;
    if (active) begin
      if (hit && !frame_cnt_q[BLINK_BIT]) begin
        rgb_d = colour_q;
      end else if (border) begin
        rgb_d = 3'b001;
      end
    end
  end

  // A corner hit flips both axes on one tick but still counts as one bounce.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    colour_d    = colour_q;
    if (frame_tick) begin
      frame_cnt_d = frame_cnt_q + 6'd1;
      if (bounce_x || bounce_y) begin
        colour_d = next_colour(colour_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      colour_q    <= 3'b111;
      rgb_q       <= 3'b000;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      colour_q    <= colour_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_in;
      vsync_q     <= vsync_in;
    end
  end

  assign px_r      = rgb_q[2];
  assign px_g      = rgb_q[1];
  assign px_b      = rgb_q[0];
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;

  always_comb begin
    dbg_o            = '0;
    dbg_o.box_x      = box_x;
    dbg_o.box_y      = box_y;
    dbg_o.dir_x      = dir_x;
    dbg_o.dir_y      = dir_y;
    dbg_o.frame_cnt  = frame_cnt_q;
    dbg_o.colour_idx = colour_q;
  end

endmodule

// File: tb/tb_vga_bounce_pixel.sv
module tb_vga_bounce_pixel;
  import vga_pkg::*;

  localparam int BOX   = 32;
  localparam int STP   = 2;
  localparam int BLINK = 5;
  localparam int XS    = (640 - BOX) / STP;  // ticks from one x limit to the other
  localparam int YS    = (480 - BOX) / STP;
  localparam int CORNER_N = 4257;             // first tick where both axes flip

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [9:0]  hcnt = '0, vcnt = '0;
  logic        hsync_in = 1'b1, vsync_in = 1'b1;
  logic        hsync_out, vsync_out, px_r, px_g, px_b;
  bounce_dbg_t dbg;

  vga_bounce_pixel #(.BOX_SIZE(BOX), .STEP(STP), .BLINK_BIT(BLINK)) dut (
    .clk      (clk),
    .rst      (rst),
    .hcnt     (hcnt),
    .vcnt     (vcnt),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out),
    .px_r     (px_r),
    .px_g     (px_g),
    .px_b     (px_b),
    .dbg_o    (dbg)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: state is just the number of frame ticks since reset
  // and the colour index; positions are a triangle wave of the tick count.
  int n  = 0;
  int ci = 7;

  function automatic int tri_pos(input int t, input int span);
    int p;
    p = t % (2 * span);
    return STP * ((p <= span) ? p : 2 * span - p);
  endfunction

  function automatic int tri_dec(input int t, input int span);
    int p;
    p = t % (2 * span);
    return ((p > span) || (p == 0 && t > 0)) ? 1 : 0;
  endfunction

  function automatic logic [2:0] model_rgb(input int h, input int v);
    int bx, by;
    bx = tri_pos(n, XS);
    by = tri_pos(n, YS);
    if (!(h < 640 && v < 480)) return 3'b000;
    if (h >= bx && h < bx + BOX && v >= by && v < by + BOX &&
        (((n % 64) >> BLINK) & 1) == 0) return 3'(ci);
    if (h == 0 || h == 639 || v == 0 || v == 479) return 3'b001;
    return 3'b000;
  endfunction

  task automatic model_tick();
    n++;
    if (n > 1 && (((n - 1) % XS) == 0 || ((n - 1) % YS) == 0))
      ci = (ci % 7) + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: one pixel-clock cycle, outputs checked #1 after the edge
  task automatic step(input int h, input int v, input logic hs, input logic vs);
    logic [2:0] exp_rgb;
    @(negedge clk);
    hcnt = 10'(h);
    vcnt = 10'(v);
    hsync_in = hs;
    vsync_in = vs;
    exp_rgb = rst ? 3'b000 : model_rgb(h, v);
    @(posedge clk);
    #1;
    chk("rgb", 32'({px_r, px_g, px_b}), 32'(exp_rgb));
    chk("hsync", 32'(hsync_out), rst ? 32'd1 : 32'(hs));
    chk("vsync", 32'(vsync_out), rst ? 32'd1 : 32'(vs));
    if (rst) begin
      n  = 0;
      ci = 7;
    end else if (h == 799 && v == 524) begin
      model_tick();
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".x"},  32'(dbg.box_x),      32'(tri_pos(n, XS)));
    chk({tag, ".y"},  32'(dbg.box_y),      32'(tri_pos(n, YS)));
    chk({tag, ".dx"}, 32'(dbg.dir_x),      32'(tri_dec(n, XS)));
    chk({tag, ".dy"}, 32'(dbg.dir_y),      32'(tri_dec(n, YS)));
    chk({tag, ".fc"}, 32'(dbg.frame_cnt),  32'(n % 64));
    chk({tag, ".ci"}, 32'(dbg.colour_idx), 32'(ci));
  endtask

  initial begin
    int h, v;
    int ci_before;

    // reset for two cycles
    rst = 1'b1;
    step(0, 0, 1'b1, 1'b1);
    step(0, 0, 1'b1, 1'b1);
    check_state("reset");
    chk("reset.x0", 32'(dbg.box_x), 32'd0);
    chk("reset.ci7", 32'(dbg.colour_idx), 32'd7);
    rst = 1'b0;

    // first frame pixels
    step(5, 5, 1'b1, 1'b1);
    chk("first.box_white", 32'({px_r, px_g, px_b}), 32'd7);
    step(700, 5, 1'b1, 1'b1);
    chk("first.blank", 32'({px_r, px_g, px_b}), 32'd0);
    step(639, 100, 1'b1, 1'b1);
    chk("first.border", 32'({px_r, px_g, px_b}), 32'd1);

    // sync alignment: the output must still show the old level before the edge
    @(negedge clk);
    hcnt = 10'd650; vcnt = 10'd490; hsync_in = 1'b0; vsync_in = 1'b0;
    #1;
    chk("align.hs_before", 32'(hsync_out), 32'd1);
    chk("align.vs_before", 32'(vsync_out), 32'd1);
    @(posedge clk);
    #1;
    chk("align.hs_after", 32'(hsync_out), 32'd0);
    chk("align.vs_after", 32'(vsync_out), 32'd0);
    step(650, 490, 1'b1, 1'b0);
    step(650, 490, 1'b1, 1'b1);

    // out-of-range counters: black and no tick
    step(810, 524, 1'b1, 1'b1);
    step(799, 600, 1'b1, 1'b1);
    step(1023, 1023, 1'b1, 1'b1);
    check_state("oor");

    // motion through the corner bounce
    for (int k = 0; k < CORNER_N; k++) begin
      ci_before = ci;
      step(799, 524, 1'b1, 1'b1);
      check_state("tick");
      if (n == 1) begin
        chk("motion.x1", 32'(dbg.box_x), 32'd2);
        chk("motion.y1", 32'(dbg.box_y), 32'd2);
      end
      if (n == XS) chk("motion.xmax", 32'(dbg.box_x), 32'd608);
      if (n == XS + 1) chk("motion.xback", 32'(dbg.box_x), 32'd606);
      if (n == CORNER_N) begin
        chk("corner.dx", 32'(dbg.dir_x), 32'(AXIS_INC));
        chk("corner.dy", 32'(dbg.dir_y), 32'(AXIS_DEC));
        chk("corner.ci_once", 32'(dbg.colour_idx), 32'((ci_before % 7) + 1));
      end
      if (n == 32 || n == 64) begin
        // blink: hidden at frame_cnt 32, visible again at 0
        step(tri_pos(n, XS) + 1, tri_pos(n, YS) + 1, 1'b1, 1'b1);
        chk("blink", 32'({px_r, px_g, px_b}), (n == 32) ? 32'd0 : 32'(ci));
      end
      if (k % 8 == 0) begin
        h = tri_pos(n, XS) + int'($urandom_range(0, BOX - 1));
        v = tri_pos(n, YS) + int'($urandom_range(0, BOX - 1));
        step(h, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        h = int'($urandom_range(0, 850));
        v = int'($urandom_range(0, 540));
        if (h == 799 && v == 524) h = 798;
        step(h, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    // mid-frame reset coinciding with a frame tick
    rst = 1'b1;
    step(799, 524, 1'b1, 1'b1);
    rst = 1'b0;
    check_state("midrst");
    chk("midrst.x0", 32'(dbg.box_x), 32'd0);
    chk("midrst.y0", 32'(dbg.box_y), 32'd0);
    step(100, 100, 1'b1, 1'b1);
    check_state("midrst.hold");
    step(799, 524, 1'b1, 1'b1);
    check_state("midrst.resume");
    chk("midrst.x2", 32'(dbg.box_x), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
